load_store_unit: RTL and testbench
==================================

# load_store_unit

CPU-side initiator for the data port of the unified `memory` block. It accepts one load or store at a time from the execute stage and drives a valid/ready request channel toward memory. Stores are byte-lane aligned, with replicated write data and byte enables. For loads it waits for the memory response, then selects the addressed byte or halfword and sign- or zero-extends it for writeback. Misaligned accesses are flagged and never reach memory.

## Interface
- `XLEN`, 32, data/address width (from `memory.vh`)
- `i_Clock`  in  1  system clock
- `i_Reset`  in  1  synchronous, active-high reset
- `i_Valid`  in  1  execute stage presents an access
- `o_Ready`  out  1  unit idle, can accept (state IDLE and `i_Reset` low)
- `i_Load_Store_Type`  in  `LS_SEL_WIDTH+1`  `LS_TYPE_*` code
- `i_Addr`  in  XLEN  byte address
- `i_Store_Data`  in  XLEN  store source (low bits used for half/byte)
- `o_Done`  out  1  one-cycle completion pulse
- `o_Load_Data`  out  XLEN  extended load result, valid with `o_Done`
- `o_Misaligned`  out  1  with `o_Done`: access rejected, no memory traffic
- `o_Mem_Req_Valid`  out  1  request to memory
- `i_Mem_Req_Ready`  in  1  memory accepts request
- `o_Mem_Write_Enable`  out  1  request is a store
- `o_Mem_Addr`  out  XLEN  word-aligned address `{addr[XLEN-1:2],2'b00}`
- `o_Mem_Write_Data`  out  XLEN  lane-replicated store data
- `o_Mem_Byte_Enable`  out  4  active byte lanes
- `i_Mem_Rsp_Valid`  in  1  read data valid
- `i_Mem_Read_Data`  in  XLEN  full word from memory

## Operation
- States: IDLE, REQUEST, WAIT_RESP, DONE.
- IDLE
  - Accept on `i_Valid & o_Ready`; latch type, address and data.
  - Misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0): go to DONE with misaligned flag set.
  - Otherwise go to REQUEST.
- REQUEST
  - `o_Mem_Req_Valid`=1; all request fields held stable until `i_Mem_Req_Ready`.
  - On handshake: a store goes to DONE; a load goes to WAIT_RESP.
- WAIT_RESP
  - On `i_Mem_Rsp_Valid`, register the extracted data and go to DONE.
  - Wait is unbounded; no timeout.
- DONE
  - `o_Done`=1 for exactly one cycle, then IDLE.
  - `o_Load_Data` is held until the next `o_Done`.
  - `o_Misaligned` is 1 only with `o_Done`, and only for a rejected access.
- Byte enables
  - Word: 1111.
  - Half: offset 0 → 0011, offset 2 → 1100.
  - Byte: `4'b0001 << addr[1:0]`.
  - Loads drive the same enables; memory may ignore them.
- Write data
  - Word: unchanged.
  - Half: `{2{d[15:0]}}`.
  - Byte: `{4{d[7:0]}}`.
- Load extraction
  - Lane selected by latched `addr[1:0]`.
  - `LOAD_HALF` and `LOAD_BYTE` sign-extend.
  - `_UNSIGNED` variants zero-extend.
  - `LOAD_WORD` passes the word through.
- Unknown type code: treated as a load word, same as `LOAD_WORD`.
- `i_Mem_Rsp_Valid` outside WAIT_RESP is ignored.

## Timing
- All outputs are registered, except `o_Ready`, which is decoded from state.
- Reset values:
  - State IDLE.
  - `o_Done`, `o_Misaligned`, `o_Mem_Req_Valid`, `o_Mem_Write_Enable` = 0.
  - `o_Load_Data`, `o_Mem_Addr`, `o_Mem_Write_Data`, `o_Mem_Byte_Enable` = 0.
- Store accepted at edge N, with ready held high: `o_Mem_Req_Valid` in cycle N+1, handshake at N+1, `o_Done` in cycle N+2.
- Load: `o_Done` is one cycle after the response cycle. With `memory`'s 1-cycle read, `o_Done` is in N+3.
- Misaligned access: `o_Done` and `o_Misaligned` in N+1.
- Throughput: one access per 3 cycles for stores and 4 for loads. `o_Ready` returns in the cycle after `o_Done`.
- Reset mid-transaction:
  - Abandon the access; `o_Mem_Req_Valid` is 0 after the reset edge.
  - No `o_Done` is produced.
  - A late response is ignored.

## Structure
- `memory.vh`: add `LS_TYPE_STORE_BYTE`, alongside the existing `LS_TYPE_*`, `LS_SEL_WIDTH` and `XLEN`.
- Local FSM state encodings stay inside this module.
- One combinational sub-module, `load_align`: inputs are word, offset and type; output is the extended result. It is reusable by the instruction-fetch side later.

## Test plan
- Store word 0xDEADBEEF to 0x100, ready held high → request in N+1 with addr 0x100, BE 1111, data 0xDEADBEEF, write enable 1; `o_Done` in N+2.
- Store byte 0xA5 to 0x103, ready low for 3 cycles → request fields held stable throughout; BE 1000, data 0xA5A5A5A5; `o_Done` one cycle after the handshake.
- Load half from 0x102, memory returns 0x8001_1234 → `o_Load_Data`=0xFFFF8001. Repeated as the unsigned variant → 0x00008001.
- Load byte unsigned from 0x101, word 0x0000F000 → 0x000000F0. Signed variant → 0xFFFFFFF0.
- Load word from 0x102 → `o_Done` and `o_Misaligned` in N+1, `o_Mem_Req_Valid` never asserted.
- Reset asserted in WAIT_RESP, response arrives 2 cycles later → no `o_Done`, `o_Ready`=1 after reset; the next access completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared type codes, widths and lane helpers for the load/store path.
// The helpers are pure functions so the fetch side can reuse them later.
package load_store_unit_pkg;

  localparam int XLEN         = 32;
  localparam int LS_SEL_WIDTH = 2;
  localparam int LS_TYPE_W    = LS_SEL_WIDTH + 1;

  localparam logic [LS_TYPE_W-1:0] LS_TYPE_LOAD_WORD          = 3'd0;
  localparam logic [LS_TYPE_W-1:0] LS_TYPE_LOAD_HALF          = 3'd1;
  localparam logic [LS_TYPE_W-1:0] LS_TYPE_LOAD_HALF_UNSIGNED = 3'd2;
  localparam logic [LS_TYPE_W-1:0] LS_TYPE_LOAD_BYTE          = 3'd3;
  localparam logic [LS_TYPE_W-1:0] LS_TYPE_LOAD_BYTE_UNSIGNED = 3'd4;
  localparam logic [LS_TYPE_W-1:0] LS_TYPE_STORE_WORD         = 3'd5;
  localparam logic [LS_TYPE_W-1:0] LS_TYPE_STORE_HALF         = 3'd6;
  localparam logic [LS_TYPE_W-1:0] LS_TYPE_STORE_BYTE         = 3'd7;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } ls_size_e;

  // Codes outside the table fall back to word size, matching LOAD_WORD.
  function automatic ls_size_e ls_size(input logic [LS_TYPE_W-1:0] ls_type);
    ls_size_e size;
    case (ls_type)
      LS_TYPE_LOAD_HALF, LS_TYPE_LOAD_HALF_UNSIGNED, LS_TYPE_STORE_HALF: size = SIZE_HALF;
      LS_TYPE_LOAD_BYTE, LS_TYPE_LOAD_BYTE_UNSIGNED, LS_TYPE_STORE_BYTE: size = SIZE_BYTE;
      default:                                                          size = SIZE_WORD;
    endcase
    return size;
  endfunction

  function automatic logic ls_is_store(input logic [LS_TYPE_W-1:0] ls_type);
    return (ls_type == LS_TYPE_STORE_WORD) || (ls_type == LS_TYPE_STORE_HALF) ||
           (ls_type == LS_TYPE_STORE_BYTE);
  endfunction

  function automatic logic ls_misaligned(input ls_size_e size, input logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_HALF: mis = offset[0];
      SIZE_WORD: mis = |offset;
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] ls_byte_enable(input ls_size_e size, input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      SIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
      SIZE_BYTE: be = 4'b0001 << offset;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] ls_write_data(input ls_size_e size,
                                                    input logic [XLEN-1:0] data);
    logic [XLEN-1:0] wdata;
    case (size)
      SIZE_HALF: wdata = {2{data[15:0]}};
      SIZE_BYTE: wdata = {4{data[7:0]}};
      default:   wdata = data;
    endcase
    return wdata;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Selects the addressed byte/halfword from a memory word and extends it.
// Purely combinational so it can sit on either the data or fetch path.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0]      i_word,
  input  logic [1:0]           i_offset,
  input  logic [LS_TYPE_W-1:0] i_type,
  output logic [XLEN-1:0]      o_data
);

  logic [XLEN-1:0] shifted;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    shifted = i_word >> {i_offset, 3'b000};
    o_data  = i_word;
    case (i_type)
      LS_TYPE_LOAD_HALF:          o_data = {{16{shifted[15]}}, shifted[15:0]};
      LS_TYPE_LOAD_HALF_UNSIGNED: o_data = {16'h0000, shifted[15:0]};
      LS_TYPE_LOAD_BYTE:          o_data = {{24{shifted[7]}}, shifted[7:0]};
      LS_TYPE_LOAD_BYTE_UNSIGNED: o_data = {24'h000000, shifted[7:0]};
      default:                    o_data = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator toward the memory data port.
// Rejects misaligned accesses locally; loads are aligned and extended on return.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Valid,
  output logic                 o_Ready,
  input  logic [LS_TYPE_W-1:0] i_Load_Store_Type,
  input  logic [XLEN-1:0]      i_Addr,
  input  logic [XLEN-1:0]      i_Store_Data,
  output logic                 o_Done,
  output logic [XLEN-1:0]      o_Load_Data,
  output logic                 o_Misaligned,
  output logic                 o_Mem_Req_Valid,
  input  logic                 i_Mem_Req_Ready,
  output logic                 o_Mem_Write_Enable,
  output logic [XLEN-1:0]      o_Mem_Addr,
  output logic [XLEN-1:0]      o_Mem_Write_Data,
  output logic [3:0]           o_Mem_Byte_Enable,
  input  logic                 i_Mem_Rsp_Valid,
  input  logic [XLEN-1:0]      i_Mem_Read_Data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT_RESP,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [LS_TYPE_W-1:0] type_q, type_d;
  logic [1:0]           offset_q, offset_d;
  logic                 done_q, done_d;
  logic                 misaligned_q, misaligned_d;
  logic [XLEN-1:0]      load_data_q, load_data_d;
  logic                 req_valid_q, req_valid_d;
  logic                 we_q, we_d;
  logic [XLEN-1:0]      mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;

  logic [XLEN-1:0]      aligned_data;
  ls_size_e             in_size;

  load_align u_load_align (
    .i_word   (i_Mem_Read_Data),
    .i_offset (offset_q),
    .i_type   (type_q),
    .o_data   (aligned_data)
  );

  assign o_Ready = (state_q == S_IDLE) && !i_Reset;
  assign in_size = ls_size(i_Load_Store_Type);

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    offset_d     = offset_q;
    done_d       = 1'b0;
    misaligned_d = 1'b0;
    load_data_d  = load_data_q;
    req_valid_d  = req_valid_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;

    case (state_q)
      S_IDLE: begin
        if (i_Valid && o_Ready) begin
          type_d   = i_Load_Store_Type;
          offset_d = i_Addr[1:0];
          if (ls_misaligned(in_size, i_Addr[1:0])) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            misaligned_d = 1'b1;
          end else begin
            state_d     = S_REQUEST;
            req_valid_d = 1'b1;
            we_d        = ls_is_store(i_Load_Store_Type);
            mem_addr_d  = {i_Addr[XLEN-1:2], 2'b00};
            wdata_d     = ls_write_data(in_size, i_Store_Data);
            be_d        = ls_byte_enable(in_size, i_Addr[1:0]);
          end
        end
      end
      S_REQUEST: begin
        if (i_Mem_Req_Ready) begin
          req_valid_d = 1'b0;
          if (we_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT_RESP;
          end
        end
      end
      S_WAIT_RESP: begin
        if (i_Mem_Rsp_Valid) begin
          load_data_d = aligned_data;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: synchronous reset inside the clocked block, and only non-blocking
  // assignments here so every flop samples pre-edge values.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= S_IDLE;
      type_q       <= LS_TYPE_LOAD_WORD;
      offset_q     <= 2'b00;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      load_data_q  <= '0;
      req_valid_q  <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      wdata_q      <= '0;
      be_q         <= 4'b0000;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      offset_q     <= offset_d;
      done_q       <= done_d;
      misaligned_q <= misaligned_d;
      load_data_q  <= load_data_d;
      req_valid_q  <= req_valid_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
    end
  end

  assign o_Done             = done_q;
  assign o_Misaligned       = misaligned_q;
  assign o_Load_Data        = load_data_q;
  assign o_Mem_Req_Valid    = req_valid_q;
  assign o_Mem_Write_Enable = we_q;
  assign o_Mem_Addr         = mem_addr_q;
  assign o_Mem_Write_Data   = wdata_q;
  assign o_Mem_Byte_Enable  = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a byte-level
// reference model; the bench itself plays the memory side.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic                 clk = 1'b0;
  logic                 i_Reset = 1'b1;
  logic                 i_Valid = 1'b0;
  logic                 o_Ready;
  logic [LS_TYPE_W-1:0] i_Load_Store_Type = '0;
  logic [XLEN-1:0]      i_Addr = '0;
  logic [XLEN-1:0]      i_Store_Data = '0;
  logic                 o_Done;
  logic [XLEN-1:0]      o_Load_Data;
  logic                 o_Misaligned;
  logic                 o_Mem_Req_Valid;
  logic                 i_Mem_Req_Ready = 1'b0;
  logic                 o_Mem_Write_Enable;
  logic [XLEN-1:0]      o_Mem_Addr;
  logic [XLEN-1:0]      o_Mem_Write_Data;
  logic [3:0]           o_Mem_Byte_Enable;
  logic                 i_Mem_Rsp_Valid = 1'b0;
  logic [XLEN-1:0]      i_Mem_Read_Data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .i_Clock            (clk),
    .i_Reset            (i_Reset),
    .i_Valid            (i_Valid),
    .o_Ready            (o_Ready),
    .i_Load_Store_Type  (i_Load_Store_Type),
    .i_Addr             (i_Addr),
    .i_Store_Data       (i_Store_Data),
    .o_Done             (o_Done),
    .o_Load_Data        (o_Load_Data),
    .o_Misaligned       (o_Misaligned),
    .o_Mem_Req_Valid    (o_Mem_Req_Valid),
    .i_Mem_Req_Ready    (i_Mem_Req_Ready),
    .o_Mem_Write_Enable (o_Mem_Write_Enable),
    .o_Mem_Addr         (o_Mem_Addr),
    .o_Mem_Write_Data   (o_Mem_Write_Data),
    .o_Mem_Byte_Enable  (o_Mem_Byte_Enable),
    .i_Mem_Rsp_Valid    (i_Mem_Rsp_Valid),
    .i_Mem_Read_Data    (i_Mem_Read_Data)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // ---------------- reference model (byte-count arithmetic) ----------------
  function automatic int access_bytes(input logic [2:0] t);
    if (t inside {LS_TYPE_LOAD_HALF, LS_TYPE_LOAD_HALF_UNSIGNED, LS_TYPE_STORE_HALF}) return 2;
    if (t inside {LS_TYPE_LOAD_BYTE, LS_TYPE_LOAD_BYTE_UNSIGNED, LS_TYPE_STORE_BYTE}) return 1;
    return 4;
  endfunction

  function automatic bit model_is_store(input logic [2:0] t);
    return t inside {LS_TYPE_STORE_WORD, LS_TYPE_STORE_HALF, LS_TYPE_STORE_BYTE};
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] t, input logic [31:0] a);
    int n   = access_bytes(t);
    int off = int'(a % 4);
    logic [3:0] be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] t, input logic [31:0] d);
    int n = access_bytes(t);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[i*8 +: 8] = d[(i % n)*8 +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a,
                                             input logic [31:0] word);
    int n   = access_bytes(t);
    int off = int'(a % 4);
    longint v;
    v = longint'(word >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
    if ((t == LS_TYPE_LOAD_HALF || t == LS_TYPE_LOAD_BYTE) && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // One complete access; starts and ends just after a falling edge.
  task automatic do_access(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                           input int rdy_wait, input logic [31:0] rsp_word, input int rsp_wait);
    string       tag;
    bit          mis;
    logic [31:0] exp_ld;
    tag    = $sformatf("t%0d@%h", t, a);
    mis    = (a % access_bytes(t)) != 0;
    exp_ld = model_load(t, a, rsp_word);

    check({tag, " ready_idle"}, o_Ready, 1);
    i_Valid = 1'b1; i_Load_Store_Type = t; i_Addr = a; i_Store_Data = d;
    @(negedge clk);
    i_Valid = 1'b0; i_Addr = $urandom; i_Store_Data = $urandom;
    i_Load_Store_Type = 3'($urandom_range(0, 7));

    if (mis) begin
      check({tag, " mis_done"}, o_Done, 1);
      check({tag, " mis_flag"}, o_Misaligned, 1);
      check({tag, " mis_noreq"}, o_Mem_Req_Valid, 0);
      @(negedge clk);
      check({tag, " mis_done_clr"}, o_Done, 0);
      check({tag, " mis_flag_clr"}, o_Misaligned, 0);
      check({tag, " mis_ready"}, o_Ready, 1);
      check({tag, " mis_noreq2"}, o_Mem_Req_Valid, 0);
      return;
    end

    for (int c = 0; c <= rdy_wait; c++) begin
      check({tag, " req_valid"}, o_Mem_Req_Valid, 1);
      check({tag, " req_we"}, o_Mem_Write_Enable, 32'(model_is_store(t)));
      check({tag, " req_addr"}, o_Mem_Addr, a & 32'hFFFF_FFFC);
      check({tag, " req_be"}, o_Mem_Byte_Enable, model_be(t, a));
      if (model_is_store(t)) check({tag, " req_wdata"}, o_Mem_Write_Data, model_wdata(t, d));
      check({tag, " req_nodone"}, o_Done, 0);
      if (c < rdy_wait) @(negedge clk);
    end
    i_Mem_Req_Ready = 1'b1;
    @(negedge clk);
    i_Mem_Req_Ready = 1'b0;
    check({tag, " req_dropped"}, o_Mem_Req_Valid, 0);

    if (model_is_store(t)) begin
      check({tag, " st_done"}, o_Done, 1);
      check({tag, " st_mis"}, o_Misaligned, 0);
    end else begin
      check({tag, " ld_wait"}, o_Done, 0);
      repeat (rsp_wait) begin
        @(negedge clk);
        check({tag, " ld_wait"}, o_Done, 0);
      end
      i_Mem_Rsp_Valid = 1'b1; i_Mem_Read_Data = rsp_word;
      @(negedge clk);
      i_Mem_Rsp_Valid = 1'b0; i_Mem_Read_Data = $urandom;
      check({tag, " ld_done"}, o_Done, 1);
      check({tag, " ld_mis"}, o_Misaligned, 0);
      check({tag, " ld_data"}, o_Load_Data, exp_ld);
    end
    @(negedge clk);
    check({tag, " done_clr"}, o_Done, 0);
    check({tag, " ready_back"}, o_Ready, 1);
    if (!model_is_store(t)) check({tag, " ld_hold"}, o_Load_Data, exp_ld);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst ready_low", o_Ready, 0);
    check("rst done", o_Done, 0);
    check("rst mis", o_Misaligned, 0);
    check("rst req_valid", o_Mem_Req_Valid, 0);
    check("rst we", o_Mem_Write_Enable, 0);
    check("rst load_data", o_Load_Data, 0);
    check("rst addr", o_Mem_Addr, 0);
    check("rst wdata", o_Mem_Write_Data, 0);
    check("rst be", o_Mem_Byte_Enable, 0);
    i_Reset = 1'b0;
    @(negedge clk);
    check("post_rst ready", o_Ready, 1);

    // Stray response while idle must be ignored
    i_Mem_Rsp_Valid = 1'b1; i_Mem_Read_Data = 32'h1234_5678;
    @(negedge clk);
    i_Mem_Rsp_Valid = 1'b0;
    check("stray_rsp done", o_Done, 0);
    check("stray_rsp ready", o_Ready, 1);

    // Directed cases
    do_access(LS_TYPE_STORE_WORD, 32'h100, 32'hDEAD_BEEF, 0, 32'h0, 0);
    do_access(LS_TYPE_STORE_BYTE, 32'h103, 32'h0000_00A5, 3, 32'h0, 0);
    do_access(LS_TYPE_STORE_HALF, 32'h102, 32'h1357_2468, 1, 32'h0, 0);
    do_access(LS_TYPE_LOAD_HALF, 32'h102, 32'h0, 0, 32'h8001_1234, 0);
    do_access(LS_TYPE_LOAD_HALF_UNSIGNED, 32'h102, 32'h0, 0, 32'h8001_1234, 0);
    do_access(LS_TYPE_LOAD_BYTE_UNSIGNED, 32'h101, 32'h0, 0, 32'h0000_F000, 0);
    do_access(LS_TYPE_LOAD_BYTE, 32'h101, 32'h0, 0, 32'h0000_F000, 0);
    do_access(LS_TYPE_LOAD_WORD, 32'h104, 32'h0, 2, 32'hCAFE_F00D, 3);
    do_access(LS_TYPE_LOAD_WORD, 32'h102, 32'h0, 0, 32'h0, 0);
    do_access(LS_TYPE_STORE_HALF, 32'h101, 32'hFFFF_FFFF, 0, 32'h0, 0);

    // Reset while waiting for a load response, response arrives late
    check("rstmid ready", o_Ready, 1);
    i_Valid = 1'b1; i_Load_Store_Type = LS_TYPE_LOAD_WORD; i_Addr = 32'h200;
    @(negedge clk);
    i_Valid = 1'b0;
    check("rstmid req", o_Mem_Req_Valid, 1);
    i_Mem_Req_Ready = 1'b1;
    @(negedge clk);
    i_Mem_Req_Ready = 1'b0;
    i_Reset = 1'b1;
    @(negedge clk);
    check("rstmid in_rst done", o_Done, 0);
    check("rstmid in_rst req", o_Mem_Req_Valid, 0);
    check("rstmid in_rst ready", o_Ready, 0);
    i_Reset = 1'b0;
    @(negedge clk);
    check("rstmid after ready", o_Ready, 1);
    check("rstmid after done", o_Done, 0);
    i_Mem_Rsp_Valid = 1'b1; i_Mem_Read_Data = 32'h7777_7777;
    @(negedge clk);
    i_Mem_Rsp_Valid = 1'b0;
    check("rstmid late_rsp done", o_Done, 0);
    check("rstmid late_rsp ready", o_Ready, 1);
    @(negedge clk);
    check("rstmid late_rsp done2", o_Done, 0);
    do_access(LS_TYPE_LOAD_BYTE, 32'h203, 32'h0, 1, 32'h80FF_0102, 1);

    // Randomized accesses
    for (int k = 0; k < 60; k++) begin
      do_access(3'($urandom_range(0, 7)), 32'h300 + 32'($urandom_range(0, 63)), $urandom,
                $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
